tilt_stepper: RTL and testbench

Conditions the raw 9-bit accelerometer tilt readings and turns them into rate-proportional step strobes for the ball-position stage. Sits between the accelerometer SPI controller (continuous `accel_x`/`accel_y` words) and the ball module (`x_increment`/`x_decrement`/`y_increment`/`y_decrement`). It replaces the direct sign-bit wiring with three stages:
- a tick-paced 4-sample moving average,
- a symmetric deadzone,
- a per-axis phase accumulator, so that ball speed scales with tilt.

---
 rtl/tilt_stepper.sv | 174 +++++++++++++++++
 tb/tb_tilt_stepper.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_stepper.sv
// Accelerometer tilt conditioner: tick-paced 4-sample moving average, symmetric
// deadzone and per-axis phase accumulators that emit rate-proportional step strobes.
module tilt_stepper #(
    parameter int SIMULATE    = 0,
    parameter int TICK_DIV    = 100000,
    parameter int DEADZONE    = 16,
    parameter int STEP_THRESH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [8:0] accel_x,
    input  logic signed [8:0] accel_y,
    output logic              x_inc,
    output logic              x_dec,
    output logic              y_inc,
    output logic              y_dec,
    output logic signed [8:0] x_tilt,
    output logic signed [8:0] y_tilt,
    output logic              active
);

    localparam int         N      = (SIMULATE != 0) ? 10 : TICK_DIV;
    localparam int         CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [8:0] DZ     = 9'(DEADZONE);
    localparam logic [9:0] THRESH = 10'(STEP_THRESH);

    typedef struct packed {
        logic [8:0] acc;
        logic       dir;   // 1 = last stepping direction was negative
        logic       inc;
        logic       dec;
        logic       busy;  // outside the deadzone
    } axis_upd_t;

    // One accumulator update for one axis, given the filtered tilt.
    function automatic axis_upd_t axis_step(
        input logic signed [8:0] avg,
        input logic        [8:0] acc,
        input logic              dir,
        input logic              en
    );
        axis_upd_t  u;
        logic       neg;
        logic [8:0] mag;
        logic [8:0] base;
        logic [9:0] sum;
        neg    = avg[8];
        mag    = neg ? 9'(-avg) : 9'(avg);
        u      = '0;
        u.dir  = dir;
        u.busy = (mag > DZ);
        if (u.busy && en) begin
            base  = (neg != dir) ? 9'd0 : acc;
            u.dir = neg;
            sum   = {1'b0, base} + {1'b0, mag - DZ};
            if (sum >= THRESH) begin
                u.acc = 9'(sum - THRESH);
                u.inc = ~neg;
                u.dec = neg;
            end else begin
                u.acc = sum[8:0];
            end
        end
        return u;
    endfunction

    logic [CW-1:0]      cnt;
    logic               tick;
    logic               tick_d1;
    logic               tick_d2;
    logic signed [8:0]  hist_x [4];
    logic signed [8:0]  hist_y [4];
    logic signed [10:0] sum_x;
    logic signed [10:0] sum_y;
    logic [8:0]         acc_x;
    logic [8:0]         acc_y;
    logic               dir_x;
    logic               dir_y;
    axis_upd_t          upd_x;
    axis_upd_t          upd_y;

    assign tick = (cnt == CW'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the history is tiny and must read as zero after reset so the first
    // average starts from an empty window; it is therefore reset explicitly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_x[i] <= '0;
                hist_y[i] <= '0;
            end
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
            x_tilt  <= '0;
            y_tilt  <= '0;
        end else begin
            tick_d1 <= tick;
            tick_d2 <= tick_d1;
            if (tick) begin
                for (int i = 3; i > 0; i--) begin
                    hist_x[i] <= hist_x[i-1];
                    hist_y[i] <= hist_y[i-1];
                end
                hist_x[0] <= accel_x;
                hist_y[0] <= accel_y;
            end
            // Bits [10:2] of the 11-bit sum are the arithmetic shift by two.
            if (tick_d1) begin
                x_tilt <= sum_x[10:2];
                y_tilt <= sum_y[10:2];
            end
        end
    end

    // NOTE: every always_comb output gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        sum_x = '0;
        sum_y = '0;
        for (int i = 0; i < 4; i++) begin
            sum_x = sum_x + $signed({{2{hist_x[i][8]}}, hist_x[i]});
            sum_y = sum_y + $signed({{2{hist_y[i][8]}}, hist_y[i]});
        end
        upd_x = axis_step(x_tilt, acc_x, dir_x, enable);
        upd_y = axis_step(y_tilt, acc_y, dir_y, enable);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_x  <= '0;
            acc_y  <= '0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
            x_inc  <= 1'b0;
            x_dec  <= 1'b0;
            y_inc  <= 1'b0;
            y_dec  <= 1'b0;
            active <= 1'b0;
        end else begin
            x_inc <= 1'b0;
            x_dec <= 1'b0;
            y_inc <= 1'b0;
            y_dec <= 1'b0;
            if (tick_d2) begin
                acc_x  <= upd_x.acc;
                acc_y  <= upd_y.acc;
                dir_x  <= upd_x.dir;
                dir_y  <= upd_y.dir;
                x_inc  <= upd_x.inc;
                x_dec  <= upd_x.dec;
                y_inc  <= upd_y.inc;
                y_dec  <= upd_y.dec;
                active <= upd_x.busy | upd_y.busy;
            end else if (!enable) begin
                acc_x <= '0;
                acc_y <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tilt_stepper.sv
// Self-checking bench for tilt_stepper: table vectors plus a per-tick behavioural
// model feeding a scoreboard, with hand-written reset/reversal/enable sequences.
module tb_tilt_stepper;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic signed [8:0] accel_x = '0;
    logic signed [8:0] accel_y = '0;
    logic              x_inc, x_dec, y_inc, y_dec, active;
    logic signed [8:0] x_tilt, y_tilt;

    always #5 clk = ~clk;

    tilt_stepper #(
        .SIMULATE(1), .TICK_DIV(100000), .DEADZONE(16), .STEP_THRESH(256)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .accel_x(accel_x), .accel_y(accel_y),
        .x_inc(x_inc), .x_dec(x_dec), .y_inc(y_inc), .y_dec(y_dec),
        .x_tilt(x_tilt), .y_tilt(y_tilt), .active(active)
    );

    typedef struct { int xt, yt, xi, xd, yi, yd, act; } exp_t;
    typedef struct { int ax, ay; bit en; exp_t e; } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   checks = 0;
    int   failures = 0;

    // Per-window and running strobe tallies observed on the DUT.
    int w_xi, w_xd, w_yi, w_yd, w_ovl;
    int t_xi, t_xd, t_yi, t_yd;

    // Reference model state.
    int m_hx[4], m_hy[4];
    int m_px, m_py, m_tx, m_ty, m_accx, m_accy;
    bit m_pend, m_dirx, m_diry, m_act;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int floor_div4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hx[i] = 0;
            m_hy[i] = 0;
        end
        m_px = 0; m_py = 0; m_tx = 0; m_ty = 0; m_accx = 0; m_accy = 0;
        m_pend = 0; m_dirx = 0; m_diry = 0; m_act = 0;
        sb.delete();
    endtask

    task automatic model_axis(input int avg, input bit en, inout int acc, inout bit dir,
                              output bit inc, output bit dec, output bit busy);
        int mag;
        bit neg;
        neg  = (avg < 0);
        mag  = neg ? -avg : avg;
        busy = (mag > 16);
        inc  = 0;
        dec  = 0;
        if (!busy || !en) begin
            acc = 0;
        end else begin
            if (neg != dir) begin
                acc = 0;
                dir = neg;
            end
            acc = acc + (mag - 16);
            if (acc >= 256) begin
                acc = acc - 256;
                if (neg) dec = 1; else inc = 1;
            end
        end
    endtask

    // Result expected at the end of this window: the previous tick's update,
    // whose accumulator step samples this window's enable.
    task automatic model_tick(input int ax, input int ay, input bit en, output exp_t e);
        bit xi, xd, yi, yd, bx, by;
        int s;
        xi = 0; xd = 0; yi = 0; yd = 0;
        if (m_pend) begin
            model_axis(m_px, en, m_accx, m_dirx, xi, xd, bx);
            model_axis(m_py, en, m_accy, m_diry, yi, yd, by);
            m_tx  = m_px;
            m_ty  = m_py;
            m_act = bx | by;
        end
        e = '{m_tx, m_ty, int'(xi), int'(xd), int'(yi), int'(yd), int'(m_act)};
        for (int i = 3; i > 0; i--) begin
            m_hx[i] = m_hx[i-1];
            m_hy[i] = m_hy[i-1];
        end
        m_hx[0] = ax;
        m_hy[0] = ay;
        s = m_hx[0] + m_hx[1] + m_hx[2] + m_hx[3];
        m_px = floor_div4(s);
        s = m_hy[0] + m_hy[1] + m_hy[2] + m_hy[3];
        m_py = floor_div4(s);
        m_pend = 1;
    endtask

    // One sample-tick window of 10 clocks; the tick loads on the last edge.
    task automatic run_tick(input int ax, input int ay, input bit en,
                            input bit use_tbl, input exp_t te);
        exp_t e, got;
        accel_x = 9'(ax);
        accel_y = 9'(ay);
        enable  = en;
        model_tick(ax, ay, en, e);
        if (use_tbl) sb.push_back(te);
        else         sb.push_back(e);
        w_xi = 0; w_xd = 0; w_yi = 0; w_yd = 0; w_ovl = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            w_xi += int'(x_inc);
            w_xd += int'(x_dec);
            w_yi += int'(y_inc);
            w_yd += int'(y_dec);
            if ((x_inc && x_dec) || (y_inc && y_dec)) w_ovl++;
        end
        t_xi += w_xi; t_xd += w_xd; t_yi += w_yi; t_yd += w_yd;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            got = sb.pop_front();
            check("x_tilt", int'(x_tilt), got.xt);
            check("y_tilt", int'(y_tilt), got.yt);
            check("x_inc_count", w_xi, got.xi);
            check("x_dec_count", w_xd, got.xd);
            check("y_inc_count", w_yi, got.yi);
            check("y_dec_count", w_yd, got.yd);
            check("active", int'(active), got.act);
            check("inc_dec_overlap", w_ovl, 0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_x_inc"}, int'(x_inc), 0);
        check({tag, "_x_dec"}, int'(x_dec), 0);
        check({tag, "_y_inc"}, int'(y_inc), 0);
        check({tag, "_y_dec"}, int'(y_dec), 0);
        check({tag, "_x_tilt"}, int'(x_tilt), 0);
        check({tag, "_y_tilt"}, int'(y_tilt), 0);
        check({tag, "_active"}, int'(active), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic clear_totals();
        t_xi = 0; t_xd = 0; t_yi = 0; t_yd = 0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 7; i++) run_tick(tbl[i].ax, tbl[i].ay, tbl[i].en, 1'b1, tbl[i].e);
    endtask

    initial begin
        exp_t none;
        int   dz_win, first_dec, win, xinc_after;
        none = '{0, 0, 0, 0, 0, 0, 0};

        // Window v reports tick v-1: X ramps +144, Y ramps to full-scale negative.
        tbl[0] = '{144, -256, 1'b1, '{   0,    0, 0, 0, 0, 0, 0}};
        tbl[1] = '{144, -256, 1'b1, '{  36,  -64, 0, 0, 0, 0, 1}};
        tbl[2] = '{144, -256, 1'b1, '{  72, -128, 0, 0, 0, 0, 1}};
        tbl[3] = '{144, -256, 1'b1, '{ 108, -192, 0, 0, 0, 1, 1}};
        tbl[4] = '{144, -256, 1'b1, '{ 144, -256, 1, 0, 0, 1, 1}};
        tbl[5] = '{144, -256, 1'b1, '{ 144, -256, 0, 0, 0, 1, 1}};
        tbl[6] = '{144, -256, 1'b1, '{ 144, -256, 1, 0, 0, 1, 1}};

        #2 reset = 1'b0;
        #2 check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        clear_totals();

        // Ramp-up, then steady state: 8 X steps and 15 Y steps per 16 ticks.
        run_table();
        clear_totals();
        for (int i = 0; i < 16; i++) run_tick(144, -256, 1'b1, 1'b0, none);
        check("steady_x_inc_16", t_xi, 8);
        check("steady_x_dec_16", t_xd, 0);
        check("fullscale_y_dec_16", t_yd, 15);
        check("fullscale_y_inc_16", t_yi, 0);

        // Deadzone: +16 / -16 never steps and never reports active.
        do_reset();
        clear_totals();
        for (int i = 0; i < 100; i++) run_tick(16, -16, 1'b1, 1'b0, none);
        check("deadzone_strobes", t_xi + t_xd + t_yi + t_yd, 0);
        check("deadzone_x_tilt", int'(x_tilt), 16);
        check("deadzone_y_tilt", int'(y_tilt), -16);

        // Reversal: +144 then -144; no inc once the average hits the deadzone.
        do_reset();
        for (int i = 0; i < 20; i++) run_tick(144, 0, 1'b1, 1'b0, none);
        dz_win = -1; first_dec = -1; xinc_after = 0;
        for (win = 0; win < 20; win++) begin
            run_tick(-144, 0, 1'b1, 1'b0, none);
            if (dz_win < 0 && m_tx <= 16 && m_tx >= -16) dz_win = win;
            if (dz_win >= 0) xinc_after += w_xi;
            if (first_dec < 0 && w_xd > 0) first_dec = win;
        end
        check("rev_x_inc_after_deadzone", xinc_after, 0);
        check("rev_first_dec_offset", first_dec - dz_win, 3);

        // Enable gating with +200 held.
        do_reset();
        for (int i = 0; i < 8; i++) run_tick(200, 0, 1'b1, 1'b0, none);
        clear_totals();
        for (int i = 0; i < 10; i++) begin
            run_tick(200, 0, 1'b0, 1'b0, none);
            check("disabled_x_tilt", int'(x_tilt), 200);
            check("disabled_active", int'(active), 1);
        end
        check("disabled_strobes", t_xi + t_xd + t_yi + t_yd, 0);
        run_tick(200, 0, 1'b1, 1'b0, none);
        check("reenable_first_window_inc", w_xi, 0);
        run_tick(200, 0, 1'b1, 1'b0, none);
        check("reenable_second_window_inc", w_xi, 1);
        for (int i = 0; i < 4; i++) run_tick(200, 0, 1'b1, 1'b0, none);

        // Asynchronous reset in the middle of a window, then a clean ramp.
        do_reset();
        for (int i = 0; i < 6; i++) run_tick(144, -256, 1'b1, 1'b0, none);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
